ysyx_25020037_ifu_fq: RTL and testbench

//  Parametrised instruction fetch unit: PC generation, I-cache lookup, AXI4 line refill and an N-entry fetch queue.

---
 rtl/ysyx_25020037_ifu_fq.sv | 253 +++++++++++++++++++++++++
 tb/tb_ysyx_25020037_ifu_fq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020037_ifu_fq.sv
// Fetch unit: PC generation, I-cache lookup, AXI4 line refill (burst or single-beat) and an N-entry fetch queue.
// Hit reaches out_* one cycle later; fetch stalls while the queue is full, and out_ready=0 only holds the head.
module ysyx_25020037_ifu_fq #(
    parameter int          BLOCK_SIZE  = 16,
    parameter int          FQ_DEPTH    = 4,
    parameter logic [31:0] RESET_PC    = 32'h30000000,
    parameter logic [3:0]  BURST_HI    = 4'hA,
    parameter logic [3:0]  BURST_LO_HI = 4'hB
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_pc,
    output logic [31:0]             out_inst,
    output logic                    out_fault,
    output logic [31:0]             icache_addr,
    input  logic                    icache_hit,
    input  logic [31:0]             icache_data,
    output logic                    refill_valid,
    output logic [31:0]             refill_addr,
    output logic [BLOCK_SIZE*8-1:0] refill_data,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [31:0]             araddr,
    output logic [3:0]              arid,
    output logic [2:0]              arsize,
    output logic [7:0]              arlen,
    output logic [1:0]              arburst,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [31:0]             rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic [3:0]              rid
);
    localparam int BEATS = BLOCK_SIZE / 4;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF   = $clog2(BLOCK_SIZE);
    localparam int PW    = $clog2(FQ_DEPTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);
    localparam logic [PW:0]   FULL_C   = (PW+1)'(FQ_DEPTH);
    localparam logic [PW:0]   ONE_C    = (PW+1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_FILL, S_DRAIN, S_HALT} state_t;

    state_t         state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [31:0]    base_q, base_d;
    logic           burst_q, burst_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           fault_q, fault_d;
    logic           drain_ar_q, drain_ar_d;
    logic           drain_r_q, drain_r_d;
    logic [31:0]    beat_q [BEATS];
    logic [31:0]    beat_d [BEATS];

    logic [31:0]    fq_pc_q    [FQ_DEPTH];
    logic [31:0]    fq_pc_d    [FQ_DEPTH];
    logic [31:0]    fq_inst_q  [FQ_DEPTH];
    logic [31:0]    fq_inst_d  [FQ_DEPTH];
    logic           fq_fault_q [FQ_DEPTH];
    logic           fq_fault_d [FQ_DEPTH];
    logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]    count_q, count_d;

    logic           full, push, pop, in_burst, beat_last, ar_fire, r_fire;
    logic [31:0]    push_inst;
    logic           push_fault;
    logic           unused_rid;

    assign unused_rid = ^rid;

    assign full      = (count_q == FULL_C);
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign out_pc    = fq_pc_q[rptr_q];
    assign out_inst  = fq_inst_q[rptr_q];
    assign out_fault = fq_fault_q[rptr_q];

    assign icache_addr = pc_q;
    assign in_burst    = (pc_q[31:28] >= BURST_HI) && (pc_q[31:28] <= BURST_LO_HI);
    assign ar_fire     = arvalid && arready;
    assign r_fire      = rvalid && rready;
    assign beat_last   = burst_q ? rlast : (cnt_q == LAST_CNT);

    assign araddr  = burst_q ? base_q : (base_q | {{(30-CW){1'b0}}, cnt_q, 2'b00});
    assign arlen   = burst_q ? 8'(BEATS - 1) : 8'd0;
    assign arburst = burst_q ? 2'b01 : 2'b00;
    assign arid    = 4'd0;
    assign arsize  = 3'd2;

    assign refill_addr = base_q;
    for (genvar k = 0; k < BEATS; k++) begin : g_line
        assign refill_data[32*k +: 32] = beat_q[k];
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        base_d       = base_q;
        burst_d      = burst_q;
        cnt_d        = cnt_q;
        fault_d      = fault_q;
        drain_ar_d   = drain_ar_q;
        drain_r_d    = drain_r_q;
        beat_d       = beat_q;
        push         = 1'b0;
        push_inst    = icache_data;
        push_fault   = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        refill_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!full) begin
                    if (icache_hit) begin
                        push = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end else begin
                        state_d = S_AR;
                        base_d  = {pc_q[31:OFF], {OFF{1'b0}}};
                        burst_d = in_burst;
                        cnt_d   = '0;
                        fault_d = 1'b0;
                    end
                end
            end
            S_AR: begin
                arvalid = 1'b1;
                if (ar_fire) state_d = S_R;
            end
            S_R: begin
                rready = 1'b1;
                if (r_fire) begin
                    beat_d[cnt_q] = rdata;
                    if (rresp != 2'b00) fault_d = 1'b1;
                    if (beat_last) begin
                        cnt_d   = '0;
                        state_d = S_FILL;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (!burst_q) state_d = S_AR;
                    end
                end
            end
            S_FILL: begin
                if (!fault_q) begin
                    refill_valid = 1'b1;
                    state_d      = S_IDLE;
                end else if (!full) begin
                    push       = 1'b1;
                    push_inst  = 32'd0;
                    push_fault = 1'b1;
                    state_d    = S_HALT;
                end
            end
            S_DRAIN: begin
                // A single-beat line abandons its remaining ARs, so only the current beat is owed.
                arvalid    = drain_ar_q;
                rready     = drain_r_q;
                drain_ar_d = drain_ar_q && !ar_fire;
                drain_r_d  = drain_r_q && !(r_fire && (burst_q ? rlast : 1'b1));
                if (!drain_ar_d && !drain_r_d) state_d = S_IDLE;
            end
            default: ;
        endcase

        if (redirect_valid) begin
            pc_d = redirect_pc;
            push = 1'b0;
            case (state_q)
                S_AR: begin
                    state_d    = S_DRAIN;
                    drain_ar_d = !ar_fire;
                    drain_r_d  = 1'b1;
                end
                S_R: begin
                    drain_ar_d = 1'b0;
                    drain_r_d  = !(r_fire && (burst_q ? rlast : 1'b1));
                    state_d    = drain_r_d ? S_DRAIN : S_IDLE;
                end
                S_DRAIN: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        fq_pc_d    = fq_pc_q;
        fq_inst_d  = fq_inst_q;
        fq_fault_d = fq_fault_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                fq_pc_d[wptr_q]    = pc_q;
                fq_inst_d[wptr_q]  = push_inst;
                fq_fault_d[wptr_q] = push_fault;
                wptr_d             = wptr_q + PW'(1);
            end
            if (pop) rptr_d = rptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + ONE_C;
            else if (!push && pop) count_d = count_q - ONE_C;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            base_q     <= '0;
            burst_q    <= 1'b0;
            cnt_q      <= '0;
            fault_q    <= 1'b0;
            drain_ar_q <= 1'b0;
            drain_r_q  <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < BEATS; i++) beat_q[i] <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                fq_pc_q[i]    <= '0;
                fq_inst_q[i]  <= '0;
                fq_fault_q[i] <= 1'b0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            base_q     <= base_d;
            burst_q    <= burst_d;
            cnt_q      <= cnt_d;
            fault_q    <= fault_d;
            drain_ar_q <= drain_ar_d;
            drain_r_q  <= drain_r_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            beat_q     <= beat_d;
            fq_pc_q    <= fq_pc_d;
            fq_inst_q  <= fq_inst_d;
            fq_fault_q <= fq_fault_d;
        end
    end
endmodule

// File: tb/tb_ysyx_25020037_ifu_fq.sv
// Directed bench for the fetch unit: reset, hit streaming, queue backpressure,
// burst and single-beat refills, redirect mid-burst and a faulting refill.
module tb_ysyx_25020037_ifu_fq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, redirect_valid, out_valid, out_ready, out_fault;
    logic [31:0]  redirect_pc, out_pc, out_inst, icache_addr, icache_data;
    logic         icache_hit, refill_valid;
    logic [31:0]  refill_addr;
    logic [127:0] refill_data;
    logic         arvalid, arready, rvalid, rready, rlast;
    logic [31:0]  araddr, rdata;
    logic [3:0]   arid, rid;
    logic [2:0]   arsize;
    logic [7:0]   arlen;
    logic [1:0]   arburst, rresp;

    ysyx_25020037_ifu_fq dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_fault(out_fault), .icache_addr(icache_addr), .icache_hit(icache_hit),
        .icache_data(icache_data), .refill_valid(refill_valid), .refill_addr(refill_addr),
        .refill_data(refill_data), .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .arid(arid), .arsize(arsize), .arlen(arlen), .arburst(arburst), .rvalid(rvalid),
        .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
    );

    // I-cache model: either hits everywhere with addr^DEAD0000, or holds the last refilled line.
    logic         always_hit  = 1'b0;
    logic         filled_vld  = 1'b0;
    logic [31:0]  filled_base = 32'd0;
    logic [127:0] filled_line = '0;
    int           refill_cnt  = 0;

    assign icache_hit  = always_hit || (filled_vld && icache_addr[31:4] == filled_base[31:4]);
    assign icache_data = always_hit ? (icache_addr ^ 32'hDEAD0000)
                                    : filled_line[icache_addr[3:2]*32 +: 32];

    always @(posedge clk) begin
        if (rst && refill_valid) begin
            filled_vld  <= 1'b1;
            filled_base <= refill_addr;
            filled_line <= refill_data;
            refill_cnt  <= refill_cnt + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic ar_accept(input string tag, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst);
        int n = 0;
        while (!arvalid && n < 20) begin tick(); n++; end
        chk({tag, "_arvalid"}, arvalid, 1'b1);
        chk({tag, "_araddr"}, araddr, addr);
        chk({tag, "_arlen"}, arlen, len);
        chk({tag, "_arburst"}, arburst, burst);
        arready = 1'b1;
        tick();
        arready = 1'b0;
    endtask

    task automatic r_beat(input string tag, input logic [31:0] d, input logic [1:0] resp,
                          input logic last);
        int n = 0;
        while (!rready && n < 20) begin tick(); n++; end
        chk({tag, "_rready"}, rready, 1'b1);
        rvalid = 1'b1; rdata = d; rresp = resp; rlast = last;
        tick();
        rvalid = 1'b0; rresp = 2'b00; rlast = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (!out_valid && n < 10) begin tick(); n++; end
        chk({tag, "_out_valid"}, out_valid, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = '0;
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_refill_valid", refill_valid, 1'b0);
        chk("rst_out_fault", out_fault, 1'b0);
        chk("rst_refill_data", refill_data, 128'd0);
        chk("rst_pc", icache_addr, 32'h30000000);
        chk("rst_arid", arid, 4'd0);
        chk("rst_arsize", arsize, 3'd2);

        // T1: back-to-back hits with one-cycle latency
        always_hit = 1'b1;
        rst = 1'b1;
        tick();
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_pc0", out_pc, 32'h30000000);
        chk("t1_inst0", out_inst, 32'hEEAD0000);
        tick(); chk("t1_pc1", out_pc, 32'h30000004);
        tick(); chk("t1_pc2", out_pc, 32'h30000008);
        tick(); chk("t1_pc3", out_pc, 32'h3000000C);

        // T2: queue fills to four entries and fetch stalls
        out_ready = 1'b0;
        redirect(32'h30000040);
        chk("t2_flush", out_valid, 1'b0);
        chk("t2_redir_pc", icache_addr, 32'h30000040);
        repeat (6) tick();
        chk("t2_stall_pc", icache_addr, 32'h30000050);
        chk("t2_head", out_pc, 32'h30000040);
        out_ready = 1'b1;
        tick(); chk("t2_pop1", out_pc, 32'h30000044);
        tick(); chk("t2_pop2", out_pc, 32'h30000048);
        tick(); chk("t2_pop3", out_pc, 32'h3000004C);
        tick(); chk("t2_pop4", out_pc, 32'h30000050);

        // T3: burst refill of line 0xA0000010
        out_ready = 1'b0;
        always_hit = 1'b0;
        redirect(32'hA0000010);
        ar_accept("t3", 32'hA0000010, 8'd3, 2'd1);
        r_beat("t3_b0", 32'hC0DE0000, 2'b00, 1'b0);
        r_beat("t3_b1", 32'hC0DE0001, 2'b00, 1'b0);
        r_beat("t3_b2", 32'hC0DE0002, 2'b00, 1'b0);
        r_beat("t3_b3", 32'hC0DE0003, 2'b00, 1'b1);
        chk("t3_refill_valid", refill_valid, 1'b1);
        chk("t3_refill_addr", refill_addr, 32'hA0000010);
        chk("t3_refill_data", refill_data,
            {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000});
        chk("t3_rready_off", rready, 1'b0);
        wait_out("t3");
        chk("t3_pc", out_pc, 32'hA0000010);
        chk("t3_inst", out_inst, 32'hC0DE0000);
        chk("t3_fault", out_fault, 1'b0);
        repeat (5) tick();
        chk("t3_one_refill", refill_cnt, 1);
        chk("t3_no_more_ar", arvalid, 1'b0);
        chk("t3_stall_pc", icache_addr, 32'hA0000020);

        // T4: single-beat refill of line 0x30000020
        redirect(32'h30000020);
        chk("t4_flush", out_valid, 1'b0);
        ar_accept("t4_ar0", 32'h30000020, 8'd0, 2'd0);
        r_beat("t4_b0", 32'hBEEF0000, 2'b00, 1'b0);
        ar_accept("t4_ar1", 32'h30000024, 8'd0, 2'd0);
        r_beat("t4_b1", 32'hBEEF0001, 2'b00, 1'b0);
        ar_accept("t4_ar2", 32'h30000028, 8'd0, 2'd0);
        r_beat("t4_b2", 32'hBEEF0002, 2'b00, 1'b0);
        chk("t4_no_early_refill", refill_cnt, 1);
        ar_accept("t4_ar3", 32'h3000002C, 8'd0, 2'd0);
        r_beat("t4_b3", 32'hBEEF0003, 2'b00, 1'b0);
        chk("t4_refill_valid", refill_valid, 1'b1);
        chk("t4_refill_addr", refill_addr, 32'h30000020);
        chk("t4_refill_data", refill_data,
            {32'hBEEF0003, 32'hBEEF0002, 32'hBEEF0001, 32'hBEEF0000});
        wait_out("t4");
        chk("t4_pc", out_pc, 32'h30000020);
        chk("t4_inst", out_inst, 32'hBEEF0000);

        // T5: redirect during beat 2 of a burst
        redirect(32'hA0000040);
        ar_accept("t5", 32'hA0000040, 8'd3, 2'd1);
        r_beat("t5_b0", 32'hF0000000, 2'b00, 1'b0);
        r_beat("t5_b1", 32'hF0000001, 2'b00, 1'b0);
        rvalid = 1'b1; rdata = 32'hF0000002; rlast = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h30000100;
        tick();
        rvalid = 1'b0; redirect_valid = 1'b0;
        chk("t5_flush", out_valid, 1'b0);
        chk("t5_drain_rready", rready, 1'b1);
        chk("t5_pc", icache_addr, 32'h30000100);
        r_beat("t5_b3", 32'hF0000003, 2'b00, 1'b1);
        always_hit = 1'b1;
        wait_out("t5");
        chk("t5_next_pc", out_pc, 32'h30000100);
        chk("t5_no_refill", refill_cnt, 2);

        // T6: error response produces a single faulting entry and halts fetch
        always_hit = 1'b0;
        redirect(32'hA0000080);
        ar_accept("t6", 32'hA0000080, 8'd3, 2'd1);
        r_beat("t6_b0", 32'h12340000, 2'b00, 1'b0);
        r_beat("t6_b1", 32'h12340001, 2'b10, 1'b0);
        r_beat("t6_b2", 32'h12340002, 2'b00, 1'b0);
        r_beat("t6_b3", 32'h12340003, 2'b00, 1'b1);
        chk("t6_no_refill_strobe", refill_valid, 1'b0);
        tick();
        chk("t6_valid", out_valid, 1'b1);
        chk("t6_pc", out_pc, 32'hA0000080);
        chk("t6_inst", out_inst, 32'd0);
        chk("t6_fault", out_fault, 1'b1);
        always_hit = 1'b1;
        repeat (3) tick();
        chk("t6_halt_ar", arvalid, 1'b0);
        chk("t6_halt_pc", icache_addr, 32'hA0000080);
        out_ready = 1'b1;
        tick();
        chk("t6_popped", out_valid, 1'b0);
        repeat (3) tick();
        chk("t6_no_fetch", out_valid, 1'b0);
        redirect(32'h30000200);
        wait_out("t6_resume");
        chk("t6_resume_pc", out_pc, 32'h30000200);
        chk("t6_resume_inst", out_inst, 32'hEEAD0200);
        chk("t6_resume_fault", out_fault, 1'b0);
        chk("t6_refills", refill_cnt, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
